// File: rtl/mac_acc_if.sv
// Sample/result bundle for mac_acc: operands and block control in, result strobe out.
interface mac_acc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
);
    logic                  in_valid;
    logic                  mode;
    logic [CNT_WIDTH-1:0]  len;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
    logic [ACC_WIDTH-1:0]  out;
    logic                  out_valid;
    logic                  ovf;
    logic                  busy;

    modport master (
        output in_valid, mode, len, a, b, c,
        input  out, out_valid, ovf, busy
    );

    modport slave (
        input  in_valid, mode, len, a, b, c,
        output out, out_valid, ovf, busy
    );
endinterface

// File: rtl/mac_acc.sv
// Two-stage multiply-accumulate: single a*b+c results or len-sample dot-product blocks.
// Define MAC_ACC_SAT_EN to clamp overflowing results to all-ones instead of wrapping.
module mac_acc #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int CNT_WIDTH  = 8
) (
    input logic      clk,
    input logic      reset_n,
    mac_acc_if.slave bus
);
    localparam int PW = 2 * DATA_WIDTH;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  eff_len, cnt_inc;

    logic [PW-1:0]         p_q, p_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic                  s1_vld_q, s1_vld_d;
    logic                  s1_first_q, s1_first_d;
    logic                  s1_last_q, s1_last_d;

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [ACC_WIDTH-1:0]  out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ovf_q, ovf_d;

    logic [ACC_WIDTH:0]    p_ext, c_ext, sum;
    logic                  ovf_run;
    logic [ACC_WIDTH-1:0]  acc_new;

    assign eff_len = (bus.len == '0) ? CNT_WIDTH'(1) : bus.len;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.in_valid && bus.mode && eff_len != CNT_WIDTH'(1)) state_d = ACCUM;
            ACCUM: if (bus.in_valid && cnt_inc == len_q)                      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample tagging: a single-sample result is both first and last of its "block".
    always_comb begin
        s1_first_d = 1'b0;
        s1_last_d  = 1'b0;
        cnt_d      = cnt_q;
        len_d      = len_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                s1_first_d = 1'b1;
                if (bus.mode && eff_len != CNT_WIDTH'(1)) begin
                    cnt_d = CNT_WIDTH'(1);
                    len_d = eff_len;
                end else begin
                    s1_last_d = 1'b1;
                end
            end
            ACCUM: if (bus.in_valid) begin
                cnt_d = cnt_inc;
                if (cnt_inc == len_q) begin
                    s1_last_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state_q == ACCUM);

    always_comb begin
        p_d      = {{DATA_WIDTH{1'b0}}, bus.a} * {{DATA_WIDTH{1'b0}}, bus.b};
        c_d      = bus.c;
        s1_vld_d = bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            len_q      <= '0;
            p_q        <= '0;
            c_q        <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            p_q        <= p_d;
            c_q        <= c_d;
            s1_vld_q   <= s1_vld_d;
            s1_first_q <= s1_first_d;
            s1_last_q  <= s1_last_d;
        end
    end

    // One guard bit above the accumulator catches the carry of every addition.
    always_comb begin
        p_ext   = {{(ACC_WIDTH + 1 - PW){1'b0}}, p_q};
        c_ext   = {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, c_q};
        sum     = s1_first_q ? (p_ext + c_ext) : ({1'b0, acc_q} + p_ext);
        ovf_run = sum[ACC_WIDTH] | (~s1_first_q & ovf_acc_q);
`ifdef MAC_ACC_SAT_EN
        acc_new = ovf_run ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
        acc_new = sum[ACC_WIDTH-1:0];
`endif
    end

    always_comb begin
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        ovf_d       = 1'b0;
        if (s1_vld_q) begin
            acc_d     = acc_new;
            ovf_acc_d = ovf_run;
            if (s1_last_q) begin
                out_d       = acc_new;
                out_valid_d = 1'b1;
                ovf_d       = ovf_run;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/mac_acc.md
MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of unsigned operands a, b, c.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, width of result/accumulator; ACC_WIDTH >= 2*DATA_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 8, width of block-length input and sample counter.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  1  a/b/c/mode/len qualified this cycle.
REQ-007 SHALL have port mode  input  1  0 = single MAC (a*b+c), 1 = dot-product accumulate.
REQ-008 SHALL have port len  input  CNT_WIDTH  samples per dot-product block.
REQ-009 SHALL have ports a, b, c  input  DATA_WIDTH each  unsigned operands.
REQ-010 SHALL have port out  output  ACC_WIDTH  result.
REQ-011 SHALL have port out_valid  output  1  one-cycle strobe qualifying out and ovf.
REQ-012 SHALL have port ovf  output  1  result exceeded ACC_WIDTH (wrapped or clamped).
REQ-013 SHALL have port busy  output  1  dot-product block in progress.

Function
REQ-014 SHALL be a 2-stage pipeline: S1 registers p = a*b (2*DATA_WIDTH bits), c, valid, effective mode; S2 adds/accumulates and registers out/out_valid/ovf.
REQ-015 SHALL, in mode 0, give out = p + c (zero-extended) with out_valid exactly 2 cycles after the in_valid sample; one result per valid sample, back-to-back at full rate.
REQ-016 SHALL accept no backpressure; in_valid low inserts a bubble, no output.
REQ-017 SHALL sample mode and len on the first valid sample of a block (state IDLE); len = 0 treated as 1.
REQ-018 SHALL keep states IDLE and ACCUM: IDLE -> ACCUM on valid sample with mode=1 and effective len > 1; ACCUM -> IDLE when the count reaches len; mode/len inputs ignored in ACCUM.
REQ-019 SHALL, in a dot-product block, initialise acc = p + c on the first sample, then acc += p on each further valid sample (c ignored after first).
REQ-020 SHALL emit out = final acc with a single out_valid pulse 2 cycles after the block's last sample; no out_valid for intermediate samples.
REQ-021 SHALL hold accumulator and counter across in_valid gaps inside a block.
REQ-022 SHALL allow a new block or mode-0 sample in the cycle immediately after a block's last sample, no bubble.
REQ-023 SHALL assert busy from the cycle after a block's first sample until the cycle after its last sample.
REQ-024 SHALL set ovf with out_valid if any addition in that result's computation carried beyond ACC_WIDTH; ovf is per-result, not sticky.
REQ-025 SHALL hold out at its last value when out_valid is low.

Reset
REQ-026 SHALL, with reset_n low at a clock edge, clear out=0, out_valid=0, ovf=0, busy=0, accumulator, counter, pipeline valids; state = IDLE.
REQ-027 SHALL abort an in-progress block on reset with no output; samples in the pipeline are discarded.

Configuration
REQ-028 SHALL honour macro MAC_ACC_SAT_EN: defined -> on overflow out clamps to all-ones (2^ACC_WIDTH-1) and accumulator stays clamped for the rest of the block; undefined -> out wraps modulo 2^ACC_WIDTH; ovf behaves identically in both.

Verification (DATA_WIDTH=4, ACC_WIDTH=8, CNT_WIDTH=4)
REQ-029 SHALL cover mode 0 back-to-back (3,5,7),(9,7,4),(13,9,5),(15,15,15) -> out 0x16,0x43,0x7A,0xF0 on consecutive cycles, each 2 cycles after input, ovf=0.
REQ-030 SHALL cover mode 1, len=3: (3,5,7),(9,7,x),(13,9,x) -> single out=0xCA, ovf=0; busy high during block.
REQ-031 SHALL cover mode 1, len=2: (15,15,15),(15,15,x) -> out=0xD1, ovf=1 without MAC_ACC_SAT_EN; out=0xFF, ovf=1 with it.
REQ-032 SHALL cover mode 1, len=3 with in_valid gaps of 2 cycles between samples, mode toggled to 0 mid-block -> out=0xCA, no extra outputs.
REQ-033 SHALL cover reset_n low for one cycle after second sample of a len=3 block, then mode 0 (3,5,7) -> no block output, next out=0x16, busy=0.
REQ-034 SHALL cover len=0 in mode 1 with (3,5,7) -> out=0x16 after 2 cycles, busy never high.
